reg_access_scoreboard: RTL and testbench
========================================

# reg_access_scoreboard

Parametrised scoreboarded register-access stage between decode and address generation. Tracks in-flight writes per architectural register with saturating pending counters and stalls decode on read-after-write hazards or counter saturation. Accepted instructions pass through a one-entry valid/ready output register. Supports flush of the held entry with reservation rollback.

## Interface
Parameters:
- REG_W, 3, register-number width; NUM_REGS = 2**REG_W tracked registers
- CNT_W, 2, pending-counter width; max outstanding writes per register = 2**CNT_W-1
- PAYLOAD_W, 64, opaque decode payload width carried through

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  kill held entry, block accept this cycle
- d_valid  in  1  decode has an instruction
- d_ready  out  1  stage accepts this cycle
- d_src0 / d_src1  in  REG_W each  source register numbers
- d_src0_en / d_src1_en  in  1 each  source is read
- d_dst  in  REG_W  destination register number
- d_dst_en  in  1  instruction writes d_dst
- d_payload  in  PAYLOAD_W  carried unchanged
- r_valid  out  1  output entry valid
- r_ready  in  1  address generation accepts
- r_dst, r_dst_en, r_payload  out  REG_W, 1, PAYLOAD_W  held copies
- wb_reg_number  in  REG_W  writeback register
- wb_reg_en  in  1  writeback releases one reservation
- busy_vec  out  NUM_REGS  bit i = count[i] != 0
- err_underflow  out  1  sticky: writeback to register with count 0

## Operation
- State: count[0..NUM_REGS-1] (CNT_W each), output register {r_valid, r_dst, r_dst_en, r_payload}, err_underflow.
- hazard = (d_src0_en & count[d_src0]!=0) | (d_src1_en & count[d_src1]!=0) | (d_dst_en & count[d_dst]==2**CNT_W-1).
- d_ready = ~hazard & ~flush & (~r_valid | r_ready). accept = d_valid & d_ready.
- Counter update per register i, computed from: inc = accept & d_dst_en & d_dst==i; dec = wb_reg_en & wb_reg_number==i & count[i]!=0; roll = flush & r_valid & r_dst_en & r_dst==i & ~(r_valid & r_ready).
- count[i] next = count[i] + inc - dec - roll, saturating at 0; inc and dec on same register leave it unchanged.
- wb_reg_en to register with count 0: no change, err_underflow set until reset.
- Output register: accept loads d_dst, d_dst_en, d_payload and sets r_valid; else r_valid & r_ready clears r_valid; flush clears r_valid (an entry handed off in the same cycle, r_valid & r_ready, is not rolled back).
- Payload register updates only on accept.

## Timing
- Reset: all count = 0, r_valid = 0, r_dst = 0, r_dst_en = 0, r_payload = 0, busy_vec = 0, err_underflow = 0; d_ready = 1 when flush = 0.
- Latency: accept in cycle N -> r_valid and reservation visible in cycle N+1.
- Full throughput: r_ready held 1, no hazards -> one accept per cycle.
- d_ready is combinational from hazard, flush, r_valid, r_ready; r_* never depend combinationally on d_*.
- Writeback release visible to hazard check the cycle after wb_reg_en (see Configuration).
- Reset mid-operation overrides flush, accept and writeback in the same cycle.
- d_valid may drop without acceptance; no stickiness requirement on decode.

## Configuration
- SCOREBOARD_BYPASS_EN defined: a source with count == 1 being written back this cycle (wb_reg_en & wb_reg_number == src) is not a hazard; saturation check likewise sees dec. RAW stall ends in the writeback cycle.
- Undefined: hazard uses registered count only; RAW stall ends one cycle after writeback.

## Test plan
- Reset, issue dst=3 then src0=3 back-to-back, r_ready=1 -> second stalls with busy_vec=0x08; wb 3 at cycle 5 -> accept at cycle 6 (cycle 5 with SCOREBOARD_BYPASS_EN).
- CNT_W=2: four dst=5 issues, no writeback -> first three accepted, fourth stalls with count[5]=3; one wb 5 -> fourth accepted next cycle.
- Same cycle accept dst=2 and wb 2 with count[2]=1 -> count[2] stays 1, busy_vec[2]=1.
- Held entry dst=7 r_valid=1 r_ready=0, assert flush -> next cycle r_valid=0, count[7]=0, d_ready=0 during flush cycle.
- wb_reg_en to register 4 with count[4]=0 -> count unchanged, err_underflow=1 until reset.
- r_ready=0 for 3 cycles with valid entry -> r_payload stable, d_ready=0; r_ready=1 -> drains and next accepts same cycle.

Source files
------------

// File: rtl/reg_access_scoreboard_if.sv
// Decode-to-address-generation bus for the register access stage: decode request, held
// output entry and writeback release, with master (environment) and slave (stage) views.
interface reg_access_scoreboard_if #(
   parameter int REG_W     = 3,
   parameter int PAYLOAD_W = 64
);
   logic                 d_valid;
   logic                 d_ready;
   logic [REG_W-1:0]     d_src0;
   logic [REG_W-1:0]     d_src1;
   logic                 d_src0_en;
   logic                 d_src1_en;
   logic [REG_W-1:0]     d_dst;
   logic                 d_dst_en;
   logic [PAYLOAD_W-1:0] d_payload;

   logic                 r_valid;
   logic                 r_ready;
   logic [REG_W-1:0]     r_dst;
   logic                 r_dst_en;
   logic [PAYLOAD_W-1:0] r_payload;

   logic [REG_W-1:0]     wb_reg_number;
   logic                 wb_reg_en;

   modport master (
      output d_valid, d_src0, d_src1, d_src0_en, d_src1_en, d_dst, d_dst_en, d_payload,
      input  d_ready,
      input  r_valid, r_dst, r_dst_en, r_payload,
      output r_ready,
      output wb_reg_number, wb_reg_en
   );

   modport slave (
      input  d_valid, d_src0, d_src1, d_src0_en, d_src1_en, d_dst, d_dst_en, d_payload,
      output d_ready,
      output r_valid, r_dst, r_dst_en, r_payload,
      input  r_ready,
      input  wb_reg_number, wb_reg_en
   );
endinterface

// File: rtl/reg_access_scoreboard.sv
// Scoreboarded register-access stage: 1-cycle accept-to-output, d_ready drops on RAW/saturation hazard,
// flush or a stalled held entry. SCOREBOARD_BYPASS_EN lets a same-cycle writeback clear the hazard.
module reg_access_scoreboard #(
   parameter int REG_W     = 3,
   parameter int CNT_W     = 2,
   parameter int PAYLOAD_W = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   reg_access_scoreboard_if.slave bus,
   output logic [2**REG_W-1:0]   busy_vec,
   output logic                  err_underflow
);
   localparam int               NUM_REGS = 2**REG_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0]     count     [NUM_REGS];
   logic [CNT_W-1:0]     count_nxt [NUM_REGS];
   logic [NUM_REGS-1:0]  inc_vec, dec_vec, roll_vec;

   logic                 r_valid_q;
   logic                 r_dst_en_q;
   logic [REG_W-1:0]     r_dst_q;
   logic [PAYLOAD_W-1:0] r_payload_q;

   logic src0_haz, src1_haz, dst_haz, hazard;
   logic ready, accept, handoff, underflow;
`ifdef SCOREBOARD_BYPASS_EN
   logic wb_src0, wb_src1, wb_dst;
`endif

   always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
      // A last outstanding write retiring this cycle no longer blocks its readers.
      wb_src0  = bus.wb_reg_en && (bus.wb_reg_number == bus.d_src0);
      wb_src1  = bus.wb_reg_en && (bus.wb_reg_number == bus.d_src1);
      wb_dst   = bus.wb_reg_en && (bus.wb_reg_number == bus.d_dst);
      src0_haz = bus.d_src0_en && (count[bus.d_src0] != '0) &&
                 !(wb_src0 && (count[bus.d_src0] == CNT_ONE));
      src1_haz = bus.d_src1_en && (count[bus.d_src1] != '0) &&
                 !(wb_src1 && (count[bus.d_src1] == CNT_ONE));
      dst_haz  = bus.d_dst_en && (count[bus.d_dst] == CNT_MAX) && !wb_dst;
`else
      src0_haz = bus.d_src0_en && (count[bus.d_src0] != '0);
      src1_haz = bus.d_src1_en && (count[bus.d_src1] != '0);
      dst_haz  = bus.d_dst_en && (count[bus.d_dst] == CNT_MAX);
`endif
      hazard    = src0_haz || src1_haz || dst_haz;
      handoff   = r_valid_q && bus.r_ready;
      ready     = !hazard && !flush && (!r_valid_q || bus.r_ready);
      accept    = bus.d_valid && ready;
      underflow = bus.wb_reg_en && (count[bus.wb_reg_number] == '0);
   end

   // inc and roll are mutually exclusive (accept requires ~flush); dec implies count != 0.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         inc_vec[i]  = accept && bus.d_dst_en && (bus.d_dst == REG_W'(i));
         dec_vec[i]  = bus.wb_reg_en && (bus.wb_reg_number == REG_W'(i)) && (count[i] != '0);
         roll_vec[i] = flush && r_valid_q && r_dst_en_q && (r_dst_q == REG_W'(i)) && !handoff;
         busy_vec[i] = (count[i] != '0);
         if (inc_vec[i] && !dec_vec[i])
            count_nxt[i] = count[i] + CNT_ONE;
         else if (!inc_vec[i] && dec_vec[i] && roll_vec[i])
            count_nxt[i] = (count[i] > CNT_ONE) ? (count[i] - CNT_W'(2)) : '0;
         else if (!inc_vec[i] && (dec_vec[i] || roll_vec[i]))
            count_nxt[i] = (count[i] != '0) ? (count[i] - CNT_ONE) : '0;
         else
            count_nxt[i] = count[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) count[i] <= '0;
         r_valid_q     <= 1'b0;
         r_dst_en_q    <= 1'b0;
         r_dst_q       <= '0;
         r_payload_q   <= '0;
         err_underflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) count[i] <= count_nxt[i];
         if (underflow) err_underflow <= 1'b1;
         if (accept) begin
            r_valid_q   <= 1'b1;
            r_dst_en_q  <= bus.d_dst_en;
            r_dst_q     <= bus.d_dst;
            r_payload_q <= bus.d_payload;
         end else if (flush || handoff) begin
            r_valid_q <= 1'b0;
         end
      end
   end

   assign bus.d_ready   = ready;
   assign bus.r_valid   = r_valid_q;
   assign bus.r_dst_en  = r_dst_en_q;
   assign bus.r_dst     = r_dst_q;
   assign bus.r_payload = r_payload_q;
endmodule

// File: tb/tb_reg_access_scoreboard.sv
// Randomised and directed bench for reg_access_scoreboard against a per-register
// outstanding-write reference model.
module tb_reg_access_scoreboard;
   localparam int REG_W     = 3;
   localparam int CNT_W     = 2;
   localparam int PAYLOAD_W = 64;
   localparam int NUM_REGS  = 8;
   localparam int CNT_MAX   = 3;
`ifdef SCOREBOARD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                clk;
   logic                reset;
   logic                flush;
   logic [NUM_REGS-1:0] busy_vec;
   logic                err_underflow;

   reg_access_scoreboard_if #(.REG_W(REG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

   reg_access_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .bus           (bus.slave),
      .busy_vec      (busy_vec),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding writes per register plus the held output entry.
   int          m_cnt [NUM_REGS];
   bit          m_rv, m_rdst_en, m_err;
   int          m_rdst;
   logic [63:0] m_pay;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit src_blocked(input bit en, input int r);
      if (!en || m_cnt[r] == 0) return 1'b0;
      if (BYPASS && bus.wb_reg_en && int'(bus.wb_reg_number) == r && m_cnt[r] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_ready();
      bit stall;
      int d;
      d = int'(bus.d_dst);
      stall = src_blocked(bus.d_src0_en, int'(bus.d_src0)) ||
              src_blocked(bus.d_src1_en, int'(bus.d_src1));
      if (bus.d_dst_en && m_cnt[d] == CNT_MAX &&
          !(BYPASS && bus.wb_reg_en && int'(bus.wb_reg_number) == d))
         stall = 1'b1;
      return !stall && !flush && (!m_rv || bus.r_ready);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
      m_rv = 0; m_rdst_en = 0; m_err = 0; m_rdst = 0; m_pay = '0;
   endtask

   task automatic set_idle();
      bus.d_valid = 0; bus.d_src0 = '0; bus.d_src1 = '0; bus.d_src0_en = 0; bus.d_src1_en = 0;
      bus.d_dst = '0; bus.d_dst_en = 0; bus.d_payload = '0; bus.r_ready = 1;
      bus.wb_reg_number = '0; bus.wb_reg_en = 0; flush = 0;
   endtask

   // Entered just after a rising edge with inputs already driven.
   task automatic step();
      bit          exp_rdy, acc, hand;
      logic [7:0]  exp_busy;
      int          nc;
      #2;
      exp_rdy = model_ready();
      check_eq("d_ready", bus.d_ready, exp_rdy);
      acc  = bus.d_valid && exp_rdy;
      hand = m_rv && bus.r_ready;
      for (int i = 0; i < NUM_REGS; i++) begin
         nc = m_cnt[i];
         if (acc && bus.d_dst_en && int'(bus.d_dst) == i) nc++;
         if (bus.wb_reg_en && int'(bus.wb_reg_number) == i) begin
            if (m_cnt[i] == 0) m_err = 1;
            else nc--;
         end
         if (flush && m_rv && m_rdst_en && !hand && m_rdst == i) nc--;
         m_cnt[i] = (nc < 0) ? 0 : nc;
      end
      if (acc) begin
         m_rv = 1; m_rdst_en = bus.d_dst_en; m_rdst = int'(bus.d_dst); m_pay = bus.d_payload;
      end else if (flush || hand) begin
         m_rv = 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REGS; i++) exp_busy[i] = (m_cnt[i] != 0);
      check_eq("r_valid", bus.r_valid, m_rv);
      check_eq("r_dst_en", bus.r_dst_en, m_rdst_en);
      check_eq("r_dst", bus.r_dst, m_rdst[2:0]);
      check_eq("r_payload", bus.r_payload, m_pay);
      check_eq("busy_vec", busy_vec, exp_busy);
      check_eq("err_underflow", err_underflow, m_err);
   endtask

   task automatic drive(input int v, input int s0e, input int s0, input int s1e, input int s1,
                        input int de, input int d, input int rr, input int fl,
                        input int we, input int wn);
      bus.d_valid = (v != 0);   bus.d_src0_en = (s0e != 0); bus.d_src0 = 3'(s0);
      bus.d_src1_en = (s1e != 0); bus.d_src1 = 3'(s1);
      bus.d_dst_en = (de != 0); bus.d_dst = 3'(d);
      bus.d_payload = {$urandom, $urandom};
      bus.r_ready = (rr != 0); flush = (fl != 0);
      bus.wb_reg_en = (we != 0); bus.wb_reg_number = 3'(wn);
      step();
   endtask

   task automatic do_reset(input bit noisy);
      reset = 1;
      if (noisy) begin
         bus.d_valid = 1; bus.d_dst_en = 1; bus.d_dst = 3'($urandom_range(0, 7));
         flush = 1; bus.wb_reg_en = 1; bus.wb_reg_number = 3'($urandom_range(0, 7));
      end
      @(posedge clk);
      #1;
      reset = 0;
      set_idle();
      model_clear();
      #1;
      check_eq("rst_r_valid", bus.r_valid, 0);
      check_eq("rst_r_dst", bus.r_dst, 0);
      check_eq("rst_r_dst_en", bus.r_dst_en, 0);
      check_eq("rst_r_payload", bus.r_payload, 0);
      check_eq("rst_busy_vec", busy_vec, 0);
      check_eq("rst_err", err_underflow, 0);
      check_eq("rst_d_ready", bus.d_ready, 1);
   endtask

   initial begin
      int wn;
      logic [63:0] held;
      reset = 1;
      set_idle();
      model_clear();
      do_reset(1'b0);

      // RAW hazard on register 3
      drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
      check_eq("raw_busy", busy_vec, 8'h08);
      drive(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
      drive(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
      drive(1, 1, 3, 0, 0, 0, 0, 1, 0, 1, 3);
      drive(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
      check_eq("raw_free", busy_vec, 8'h00);

      // Counter saturation on register 5
      do_reset(1'b0);
      repeat (4) drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
      check_eq("sat_busy", busy_vec, 8'h20);
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 5);
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // Same-cycle reserve and release on register 2
      do_reset(1'b0);
      drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 2);
      check_eq("incdec_busy", busy_vec, 8'h04);

      // Flush of a stalled entry rolls back its reservation
      do_reset(1'b0);
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      check_eq("flush_r_valid", bus.r_valid, 0);
      check_eq("flush_busy", busy_vec, 8'h00);

      // Writeback underflow is sticky
      do_reset(1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4);
      check_eq("uflow_set", err_underflow, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      check_eq("uflow_hold", err_underflow, 1);
      check_eq("uflow_busy", busy_vec, 8'h00);

      // Output backpressure
      do_reset(1'b0);
      drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
      held = bus.r_payload;
      repeat (3) drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
      check_eq("bp_payload", bus.r_payload, held);
      drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
      check_eq("bp_drain_dst", bus.r_dst, 6);

      // Random traffic with occasional mid-operation reset
      for (int c = 0; c < 3000; c++) begin
         if (c % 600 == 599) begin
            do_reset(1'b1);
         end else begin
            wn = $urandom_range(0, 7);
            for (int t = 0; t < 4 && m_cnt[wn] == 0; t++) wn = $urandom_range(0, 7);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 3, wn);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
